// File: rtl/fft_twiddle_addr_gen.sv
// Radix-2 DIT FFT butterfly/twiddle address sequencer.
// Walks all stages and butterflies; valid/last are delayed to match ROM latency.
module fft_twiddle_addr_gen #(
  parameter int LOG2N = 10,
  parameter int TW_AW = LOG2N-1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             start,
  output logic [TW_AW-1:0] tw_addr,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [3:0]       stage,
  output logic             addr_vld,
  output logic             data_vld,
  output logic             data_last,
  output logic             busy,
  output logic             done
);

  localparam int JW = LOG2N-1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  state_t          state;
  logic [3:0]      s;
  logic [3:0]      ns;
  logic [JW-1:0]   j;
  logic [JW-1:0]   nj;
  logic            last;
  logic [LOG2N-1:0] half;
  logic [LOG2N-1:0] mask;
  logic [LOG2N-1:0] jx;
  logic [LOG2N-1:0] kx;
  logic [LOG2N-1:0] na;
  logic [LOG2N-1:0] nb;
  logic [TW_AW-1:0] ntw;

  assign stage = s;

  // Next butterfly index and its addresses (a = j with a 0 inserted at bit s).
  always_comb begin
    last = (s == 4'(LOG2N-1)) && (j == {JW{1'b1}});
    ns   = '0;
    nj   = '0;
    if (state == RUN) begin
      if (j == {JW{1'b1}}) begin
        ns = s + 4'd1;
        nj = '0;
      end else begin
        ns = s;
        nj = j + 1'b1;
      end
    end
    half = LOG2N'(1) << ns;
    mask = half - 1'b1;
    jx   = LOG2N'(nj);
    kx   = jx & mask;
    na   = ((jx & ~mask) << 1) | kx;
    nb   = na + half;
    ntw  = TW_AW'(kx << (4'(LOG2N-1) - ns));
  end

  // Sequencer FSM with registered outputs; everything holds when clk_en is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      s         <= '0;
      j         <= '0;
      tw_addr   <= '0;
      addr_a    <= '0;
      addr_b    <= '0;
      addr_vld  <= 1'b0;
      data_vld  <= 1'b0;
      data_last <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (clk_en) begin
      data_vld <= addr_vld;
      unique case (state)
        IDLE: begin
          data_last <= 1'b0;
          done      <= 1'b0;
          if (start) begin
            state    <= RUN;
            s        <= ns;
            j        <= nj;
            tw_addr  <= ntw;
            addr_a   <= na;
            addr_b   <= nb;
            addr_vld <= 1'b1;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          if (last) begin
            state     <= FLUSH;
            addr_vld  <= 1'b0;
            data_last <= 1'b1;
            done      <= 1'b1;
          end else begin
            s       <= ns;
            j       <= nj;
            tw_addr <= ntw;
            addr_a  <= na;
            addr_b  <= nb;
          end
        end
        FLUSH: begin
          state     <= IDLE;
          data_last <= 1'b0;
          done      <= 1'b0;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_twiddle_addr_gen.sv
// Bench for fft_twiddle_addr_gen: issue-index model plus
// directed runs (steady, gated clk_en, ignored start, mid-run reset).
module tb_fft_twiddle_addr_gen;

  localparam int HALFN = 512;
  localparam int TOTAL = 5120;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_en;
  logic       start;
  logic [8:0] tw_addr;
  logic [9:0] addr_a;
  logic [9:0] addr_b;
  logic [3:0] stage;
  logic       addr_vld;
  logic       data_vld;
  logic       data_last;
  logic       busy;
  logic       done;

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;
  bit rand_en = 1'b0;
  bit en_at_edge = 1'b0;
  int done_cnt = 0;
  int dvld_cnt = 0;

  logic [32:0] cap[$];
  logic [32:0] ref_q[$];

  fft_twiddle_addr_gen dut (
    .clk(clk),
    .rst(rst),
    .clk_en(clk_en),
    .start(start),
    .tw_addr(tw_addr),
    .addr_a(addr_a),
    .addr_b(addr_b),
    .stage(stage),
    .addr_vld(addr_vld),
    .data_vld(data_vld),
    .data_last(data_last),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] pk(input int tw, input int a,
                                     input int b, input int st);
    return {9'(tw), 10'(a), 10'(b), 4'(st)};
  endfunction

  // Expected addresses for the n-th butterfly of the whole transform.
  function automatic logic [32:0] exp_pack(input int n);
    int s, j, half, k, g, a, b, tw;
    s    = n / HALFN;
    j    = n % HALFN;
    half = 2 ** s;
    k    = j % half;
    g    = j / half;
    a    = g * 2 * half + k;
    b    = a + half;
    tw   = k * (HALFN / half);
    return pk(tw, a, b, s);
  endfunction

  // Reference model: phase 0 idle, 1 issuing butterfly m_n, 2 flush.
  int          m_phase = 0;
  int          m_n = 0;
  logic [32:0] e_addr = '0;
  logic        e_vld = 1'b0;
  logic        e_dvld = 1'b0;
  logic        e_last = 1'b0;
  logic        e_busy = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase <= 0;
      m_n     <= 0;
      e_addr  <= '0;
      e_vld   <= 1'b0;
      e_dvld  <= 1'b0;
      e_last  <= 1'b0;
      e_busy  <= 1'b0;
    end else if (clk_en) begin
      e_dvld <= e_vld;
      if (m_phase == 0) begin
        e_last <= 1'b0;
        if (start) begin
          m_phase <= 1;
          m_n     <= 0;
          e_addr  <= exp_pack(0);
          e_vld   <= 1'b1;
          e_busy  <= 1'b1;
        end
      end else if (m_phase == 1) begin
        if (m_n == TOTAL-1) begin
          m_phase <= 2;
          e_vld   <= 1'b0;
          e_last  <= 1'b1;
        end else begin
          m_n    <= m_n + 1;
          e_addr <= exp_pack(m_n + 1);
        end
      end else begin
        m_phase <= 0;
        e_last  <= 1'b0;
        e_busy  <= 1'b0;
      end
    end
  end

  always @(posedge clk) en_at_edge = clk_en;

  // Per-cycle compare against the model, plus capture of issued butterflies.
  always @(negedge clk) begin
    logic [37:0] got, exp;
    got = {tw_addr, addr_a, addr_b, stage,
           addr_vld, data_vld, data_last, busy, done};
    exp = {e_addr, e_vld, e_dvld, e_last, e_busy, e_last};
    if (chk_on) begin
      checks++;
      if (got !== exp) begin
        failures++;
        if (failures <= 20)
          $display("FAIL cycle t=%0t got=%h exp=%h", $time, got, exp);
      end
    end
    if (rst && en_at_edge) begin
      if (addr_vld) cap.push_back({tw_addr, addr_a, addr_b, stage});
      if (done) done_cnt++;
      if (data_vld) dvld_cnt++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clk_en = (rand_en && ($urandom_range(0, 99) < 30)) ? 1'b0 : 1'b1;
  endtask

  task automatic pulse_start();
    start  = 1'b1;
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic clear_run();
    cap.delete();
    done_cnt = 0;
    dvld_cnt = 0;
  endtask

  task automatic run_to_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      step();
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      failures++;
      $display("FAIL %s_timeout busy=%0b required=0", nm, busy);
    end
    clk_en = 1'b1;
    step();
  endtask

  task automatic wait_for(input string nm, input int st, input int a);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      step();
      if (addr_vld && stage == 4'(st) && addr_a == 10'(a)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      failures++;
      $display("FAIL %s_timeout stage=%0d a=%0d", nm, stage, addr_a);
    end
  endtask

  task automatic cmp_ref(input string nm);
    int bad;
    bad = 0;
    chk({nm, "_len"}, 64'(cap.size()), 64'(TOTAL));
    for (int i = 0; i < cap.size() && i < ref_q.size(); i++)
      if (cap[i] !== ref_q[i]) bad++;
    chk({nm, "_seq_mismatches"}, 64'(bad), 64'd0);
  endtask

  initial begin
    int bad;
    rst    = 1'b0;
    start  = 1'b0;
    clk_en = 1'b1;
    step();
    chk_on = 1'b1;
    step();
    chk("reset_outs",
        {tw_addr, addr_a, addr_b, stage, addr_vld, data_vld,
         data_last, busy, done}, 64'd0);
    rst = 1'b1;
    step();
    step();

    // Run 1: clk_en held high.
    clear_run();
    chk("vld_before_start", 64'(addr_vld), 64'd0);
    pulse_start();
    chk("vld_rise", 64'(addr_vld), 64'd1);
    chk("busy_rise", 64'(busy), 64'd1);
    run_to_idle("run1");
    chk("run1_count", 64'(cap.size()), 64'(TOTAL));
    chk("s0_j0", 64'(cap[0]), 64'(pk(0, 0, 1, 0)));
    chk("s0_j1", 64'(cap[1]), 64'(pk(0, 2, 3, 0)));
    bad = 0;
    for (int i = 0; i < HALFN && i < cap.size(); i++)
      if (cap[i][32:24] != 9'd0) bad++;
    chk("s0_tw_zero", 64'(bad), 64'd0);
    chk("s1_j0", 64'(cap[512]), 64'(pk(0, 0, 2, 1)));
    chk("s1_j1", 64'(cap[513]), 64'(pk(256, 1, 3, 1)));
    chk("s1_j2", 64'(cap[514]), 64'(pk(0, 4, 6, 1)));
    chk("s9_j511", 64'(cap[TOTAL-1]), 64'(pk(511, 511, 1023, 9)));
    chk("run1_done", 64'(done_cnt), 64'd1);
    chk("run1_dvld", 64'(dvld_cnt), 64'(TOTAL));
    ref_q = cap;

    // Run 2: clk_en randomly low about 30% of cycles.
    clear_run();
    pulse_start();
    rand_en = 1'b1;
    run_to_idle("run2");
    rand_en = 1'b0;
    cmp_ref("run2");
    chk("run2_done", 64'(done_cnt), 64'd1);
    chk("run2_dvld", 64'(dvld_cnt), 64'(TOTAL));

    // Run 3: start pulsed at stage 3, j=100 is ignored.
    clear_run();
    pulse_start();
    wait_for("run3", 3, 196);
    pulse_start();
    run_to_idle("run3");
    cmp_ref("run3");
    chk("run3_done", 64'(done_cnt), 64'd1);

    // Run 4: asynchronous reset at stage 4, j=37, then restart.
    clear_run();
    pulse_start();
    wait_for("run4", 4, 69);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_outs",
        {tw_addr, addr_a, addr_b, stage, addr_vld, data_vld,
         data_last, busy, done}, 64'd0);
    step();
    step();
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    chk("abort_count", 64'(cap.size()), 64'd2085);
    rst = 1'b1;
    step();
    clear_run();
    pulse_start();
    chk("restart_first",
        {addr_vld, tw_addr, addr_a, addr_b, stage},
        {1'b1, pk(0, 0, 1, 0)});
    run_to_idle("run4");
    cmp_ref("run4");
    chk("run4_done", 64'(done_cnt), 64'd1);

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
